// File: rtl/con_bus_scheduler.sv
// con_bus_scheduler
//   Time-shares the external connection bus between host-to-device load
//   beats (requested by the controller) and device-to-host result words
//   (pushed by the output data shifter into an internal FIFO). Every
//   direction change passes through a one-cycle dead turnaround state so
//   the two sides never drive the bus together.
//
// Ports
//   clk, arst_n_in          rising-edge clock, asynchronous active-low reset
//   ld_req                  controller wants load words (level)
//   ld_grant                load direction currently owned by controller
//   ld_valid                load beat accepted this cycle
//   out_wr, out_wdata       result word push
//   out_full                FIFO full, a push this cycle is dropped
//   overflow                sticky flag: a push was attempted while full
//   con_valid, con_ready    host->device load handshake
//   dev_valid, dev_ready    device->host result handshake
//   dev_data                FIFO head word
//   driving_cons            1 while the device owns the bus
//   fifo_count              FIFO occupancy
module con_bus_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 12
) (
  input  logic                            clk,
  input  logic                            arst_n_in,
  input  logic                            ld_req,
  output logic                            ld_grant,
  output logic                            ld_valid,
  input  logic                            out_wr,
  input  logic [DATA_WIDTH-1:0]           out_wdata,
  output logic                            out_full,
  output logic                            overflow,
  input  logic                            con_valid,
  output logic                            con_ready,
  output logic                            dev_valid,
  input  logic                            dev_ready,
  output logic [DATA_WIDTH-1:0]           dev_data,
  output logic                            driving_cons,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int BST_W = $clog2(MAX_BURST + 1);

  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] HIGH_WATER = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [CNT_W-1:0] ONE_CNT    = CNT_W'(1);
  localparam logic [BST_W-1:0] BURST_MAX  = BST_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TURN_OUT,
    S_DRAIN,
    S_TURN_IN
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [BST_W-1:0]        burst_cnt;
  logic [BST_W-1:0]        burst_inc;
  logic [BST_W-1:0]        burst_nxt;
  logic                    burst_hit;
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count_nxt;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic                    push;
  logic                    pop;
  logic                    drain_empties;

  // Saturating beat counter step: holds at MAX_BURST once reached.
  function automatic logic [BST_W-1:0] burst_sat_inc(input logic [BST_W-1:0] v,
                                                     input logic             en);
    if (en && (v != BURST_MAX)) begin
      return v + BST_W'(1);
    end
    return v;
  endfunction

  // Bus ownership and handshakes, all decoded from registered state
  assign driving_cons = (state == S_TURN_OUT) || (state == S_DRAIN);
  assign ld_grant     = (state == S_LOAD);
  assign con_ready    = (state == S_LOAD) && ld_req;
  assign ld_valid     = con_ready && con_valid;
  assign dev_valid    = (state == S_DRAIN) && (fifo_count != '0);
  assign dev_data     = mem[rd_ptr];

  // FIFO control: fullness comes from the registered count, so a push in a
  // full cycle is dropped even if a pop frees a slot in that same cycle.
  assign out_full  = (fifo_count == FULL_CNT);
  assign push      = out_wr && !out_full;
  assign pop       = dev_valid && dev_ready;
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);

  // Burst accounting includes the beat of the current cycle
  assign burst_inc = burst_sat_inc(burst_cnt, ld_valid || pop);
  assign burst_hit = (burst_inc == BURST_MAX);

  // FIFO empties at the end of this cycle (or already is)
  assign drain_empties = (fifo_count == '0) ||
                         ((fifo_count == ONE_CNT) && pop && !push);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          state_nxt = S_TURN_OUT;
        end else if (ld_req) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!ld_req) begin
          state_nxt = S_IDLE;
        end else if (fifo_count >= HIGH_WATER) begin
          state_nxt = S_TURN_OUT;
        end else if ((fifo_count != '0) && burst_hit) begin
          state_nxt = S_TURN_OUT;
        end
      end
      S_TURN_OUT: begin
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_empties) begin
          state_nxt = S_TURN_IN;
        end else if (ld_req && burst_hit) begin
          state_nxt = S_TURN_IN;
        end
      end
      S_TURN_IN: begin
        state_nxt = ld_req ? S_LOAD : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Burst count restarts whenever the state changes
  assign burst_nxt = (state_nxt != state) ? '0 : burst_inc;

  // Control registers
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state      <= S_IDLE;
      burst_cnt  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      burst_cnt  <= burst_nxt;
      fifo_count <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (out_wr && out_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= out_wdata;
    end
  end

endmodule

// File: tb/tb_con_bus_scheduler.sv
// tb_con_bus_scheduler
//   Directed bench for con_bus_scheduler. A queue-based reference model of
//   the bus arbitration is advanced on every clock and compared against the
//   DUT at every falling edge; scenario-level literal checks pin the model.
module tb_con_bus_scheduler;

  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int MAX_BURST  = 12;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic                  clk       = 1'b0;
  logic                  arst_n_in = 1'b1;
  logic                  ld_req    = 1'b0;
  logic                  out_wr    = 1'b0;
  logic                  con_valid = 1'b0;
  logic                  dev_ready = 1'b0;
  logic [DATA_WIDTH-1:0] out_wdata = '0;
  logic                  ld_grant;
  logic                  ld_valid;
  logic                  out_full;
  logic                  overflow;
  logic                  con_ready;
  logic                  dev_valid;
  logic [DATA_WIDTH-1:0] dev_data;
  logic                  driving_cons;
  logic [CNT_W-1:0]      fifo_count;

  int total = 0;
  int bad   = 0;
  int ldv_seen = 0;
  int drv_seen = 0;
  logic [DATA_WIDTH-1:0] pop_log[$];

  con_bus_scheduler #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .arst_n_in   (arst_n_in),
    .ld_req      (ld_req),
    .ld_grant    (ld_grant),
    .ld_valid    (ld_valid),
    .out_wr      (out_wr),
    .out_wdata   (out_wdata),
    .out_full    (out_full),
    .overflow    (overflow),
    .con_valid   (con_valid),
    .con_ready   (con_ready),
    .dev_valid   (dev_valid),
    .dev_ready   (dev_ready),
    .dev_data    (dev_data),
    .driving_cons(driving_cons),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // Reference model: who owns the bus, how many beats the current owner has
  // made, and the result queue.
  localparam int M_IDLE    = 0;
  localparam int M_HOST    = 1;
  localparam int M_GAP_OUT = 2;
  localparam int M_DEV     = 3;
  localparam int M_GAP_IN  = 4;

  int                    m_phase = M_IDLE;
  int                    m_beats = 0;
  bit                    m_ovf   = 1'b0;
  logic [DATA_WIDTH-1:0] m_q[$];

  function automatic bit e_drv();
    return (m_phase == M_GAP_OUT) || (m_phase == M_DEV);
  endfunction
  function automatic bit e_grant();
    return m_phase == M_HOST;
  endfunction
  function automatic bit e_cr();
    return (m_phase == M_HOST) && (ld_req == 1'b1);
  endfunction
  function automatic bit e_ldv();
    return e_cr() && (con_valid == 1'b1);
  endfunction
  function automatic bit e_dv();
    return (m_phase == M_DEV) && (m_q.size() != 0);
  endfunction
  function automatic bit f_push();
    return (out_wr == 1'b1) && (m_q.size() < FIFO_DEPTH);
  endfunction
  function automatic bit f_pop();
    return e_dv() && (dev_ready == 1'b1);
  endfunction
  function automatic int f_nb();
    int s = m_beats + ((e_ldv() || f_pop()) ? 1 : 0);
    return (s > MAX_BURST) ? MAX_BURST : s;
  endfunction
  function automatic int f_next_phase();
    int n = m_q.size();
    case (m_phase)
      M_IDLE:    return (n != 0) ? M_GAP_OUT : ((ld_req == 1'b1) ? M_HOST : M_IDLE);
      M_HOST: begin
        if (ld_req != 1'b1) return M_IDLE;
        if (n >= FIFO_DEPTH - 2) return M_GAP_OUT;
        if (n != 0 && f_nb() == MAX_BURST) return M_GAP_OUT;
        return M_HOST;
      end
      M_GAP_OUT: return M_DEV;
      M_DEV: begin
        if (n == 0 || (n == 1 && f_pop() && !f_push())) return M_GAP_IN;
        if (ld_req == 1'b1 && f_nb() == MAX_BURST) return M_GAP_IN;
        return M_DEV;
      end
      default:   return (ld_req == 1'b1) ? M_HOST : M_IDLE;
    endcase
  endfunction

  always @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      m_phase <= M_IDLE;
      m_beats <= 0;
      m_ovf   <= 1'b0;
      m_q.delete();
    end else begin
      m_phase <= f_next_phase();
      m_beats <= (f_next_phase() != m_phase) ? 0 : f_nb();
      if (out_wr == 1'b1 && m_q.size() == FIFO_DEPTH) m_ovf <= 1'b1;
      case ({f_push(), f_pop()})
        2'b10:   m_q.push_back(out_wdata);
        2'b01:   void'(m_q.pop_front());
        2'b11:   begin void'(m_q.pop_front()); m_q.push_back(out_wdata); end
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("driving_cons", 32'(driving_cons), 32'(e_drv()));
    chk("ld_grant",     32'(ld_grant),     32'(e_grant()));
    chk("con_ready",    32'(con_ready),    32'(e_cr()));
    chk("ld_valid",     32'(ld_valid),     32'(e_ldv()));
    chk("dev_valid",    32'(dev_valid),    32'(e_dv()));
    chk("out_full",     32'(out_full),     32'(m_q.size() == FIFO_DEPTH));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("fifo_count",   32'(fifo_count),   32'(m_q.size()));
    if (e_dv()) chk("dev_data", 32'(dev_data), 32'(m_q[0]));
  endtask

  // One clock: compare at the falling edge, log events, return just after
  // the next rising edge so new inputs can be applied.
  task automatic tick();
    @(negedge clk);
    compare_all();
    if (arst_n_in) begin
      if (ld_valid) ldv_seen++;
      if (driving_cons) drv_seen++;
      if (dev_valid && dev_ready) pop_log.push_back(dev_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base_ldv;
    int base_drv;
    int pop_base;

    #1 arst_n_in = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_driving_cons", 32'(driving_cons), 32'd0);
    chk("rst_con_ready",    32'(con_ready),    32'd0);
    chk("rst_dev_valid",    32'(dev_valid),    32'd0);
    chk("rst_fifo_count",   32'(fifo_count),   32'd0);
    chk("rst_overflow",     32'(overflow),     32'd0);
    tick();
    tick();
    arst_n_in = 1'b1;
    tick();
    tick();

    // Load only: 20 back-to-back beats, bus never turned around
    base_ldv = ldv_seen;
    base_drv = drv_seen;
    ld_req = 1'b1; con_valid = 1'b1;
    #1 chk("s1_con_ready_c0", 32'(con_ready), 32'd0);
    tick();
    #1 chk("s1_con_ready_c1", 32'(con_ready), 32'd1);
    repeat (20) tick();
    ld_req = 1'b0; con_valid = 1'b0;
    #1;
    chk("s1_beats", 32'(ldv_seen - base_ldv), 32'd20);
    chk("s1_driving", 32'(drv_seen - base_drv), 32'd0);
    repeat (3) tick();

    // Preemption: one result pushed at beat 3 waits for the 12-beat limit
    base_ldv = ldv_seen;
    base_drv = drv_seen;
    pop_base = pop_log.size();
    dev_ready = 1'b1;
    ld_req = 1'b1; con_valid = 1'b1;
    tick();
    tick();
    tick();
    out_wr = 1'b1; out_wdata = 16'hA5A5;
    tick();
    out_wr = 1'b0;
    repeat (8) tick();
    #1 chk("s2_con_ready_beat12", 32'(con_ready), 32'd1);
    tick();
    #1;
    chk("s2_turn_out_drv", 32'(driving_cons), 32'd1);
    chk("s2_turn_out_cr",  32'(con_ready),    32'd0);
    chk("s2_turn_out_dv",  32'(dev_valid),    32'd0);
    tick();
    #1;
    chk("s2_drain_dv",   32'(dev_valid), 32'd1);
    chk("s2_drain_data", 32'(dev_data),  32'hA5A5);
    tick();
    #1;
    chk("s2_turn_in_drv", 32'(driving_cons), 32'd0);
    chk("s2_turn_in_cr",  32'(con_ready),    32'd0);
    tick();
    #1;
    chk("s2_resume_cr", 32'(con_ready), 32'd1);
    chk("s2_beats", 32'(ldv_seen - base_ldv), 32'd12);
    chk("s2_drive_cycles", 32'(drv_seen - base_drv), 32'd2);
    chk("s2_pops", 32'(pop_log.size() - pop_base), 32'd1);
    if (pop_log.size() > pop_base) chk("s2_pop_data", 32'(pop_log[pop_base]), 32'hA5A5);
    ld_req = 1'b0; con_valid = 1'b0;
    repeat (3) tick();

    // High water: six results with no load beats force the turnaround
    pop_base = pop_log.size();
    ld_req = 1'b1;
    tick();
    for (int i = 1; i <= 6; i++) begin
      out_wr = 1'b1; out_wdata = 16'(32'h1000 + i);
      tick();
    end
    out_wr = 1'b0;
    #1;
    chk("s3_count6", 32'(fifo_count), 32'd6);
    chk("s3_still_load", 32'(ld_grant), 32'd1);
    tick();
    #1;
    chk("s3_turn_out_drv", 32'(driving_cons), 32'd1);
    chk("s3_turn_out_dv",  32'(dev_valid),    32'd0);
    tick();
    #1;
    chk("s3_first_dv",   32'(dev_valid), 32'd1);
    chk("s3_first_data", 32'(dev_data),  32'h1001);
    repeat (6) tick();
    #1;
    chk("s3_turn_in_drv", 32'(driving_cons), 32'd0);
    chk("s3_empty",       32'(fifo_count),   32'd0);
    tick();
    #1 chk("s3_reload", 32'(ld_grant), 32'd1);
    chk("s3_pops", 32'(pop_log.size() - pop_base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (pop_log.size() > pop_base + i)
        chk("s3_order", 32'(pop_log[pop_base + i]), 32'h1001 + 32'(i));
    end
    ld_req = 1'b0;
    repeat (3) tick();

    // Backpressure: nine pushes into eight slots
    pop_base = pop_log.size();
    dev_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      out_wr = 1'b1; out_wdata = 16'(32'h2000 + i);
      if (i == 9) begin
        #1;
        chk("s4_full",      32'(out_full),   32'd1);
        chk("s4_count8",    32'(fifo_count), 32'd8);
        chk("s4_no_ovf_yet", 32'(overflow),  32'd0);
      end
      tick();
    end
    out_wr = 1'b0; dev_ready = 1'b1;
    #1;
    chk("s4_ovf_set", 32'(overflow),   32'd1);
    chk("s4_dropped", 32'(fifo_count), 32'd8);
    repeat (8) tick();
    #1;
    chk("s4_turn_in_drv", 32'(driving_cons), 32'd0);
    chk("s4_ovf_sticky",  32'(overflow),     32'd1);
    chk("s4_not_full",    32'(out_full),     32'd0);
    chk("s4_pops", 32'(pop_log.size() - pop_base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (pop_log.size() > pop_base + i)
        chk("s4_order", 32'(pop_log[pop_base + i]), 32'h2001 + 32'(i));
    end
    repeat (3) tick();

    // Push and pop together at count 1 keeps the device on the bus
    pop_base = pop_log.size();
    out_wr = 1'b1; out_wdata = 16'h3001;
    tick();
    out_wr = 1'b0;
    tick();
    tick();
    out_wr = 1'b1; out_wdata = 16'h3002;
    #1;
    chk("s5_drain_c3", 32'(dev_valid),  32'd1);
    chk("s5_count_c3", 32'(fifo_count), 32'd1);
    tick();
    out_wr = 1'b0;
    #1;
    chk("s5_stay_drv",  32'(driving_cons), 32'd1);
    chk("s5_stay_cnt",  32'(fifo_count),   32'd1);
    chk("s5_head_data", 32'(dev_data),     32'h3002);
    tick();
    #1;
    chk("s5_turn_in_drv", 32'(driving_cons), 32'd0);
    chk("s5_pops", 32'(pop_log.size() - pop_base), 32'd2);
    repeat (3) tick();

    // Reset in the middle of a drain
    dev_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      out_wr = 1'b1; out_wdata = 16'(32'h4000 + i);
      tick();
    end
    out_wr = 1'b0;
    #1;
    chk("s6_count5",  32'(fifo_count),   32'd5);
    chk("s6_driving", 32'(driving_cons), 32'd1);
    arst_n_in = 1'b0;
    #1;
    chk("s6_rst_drv", 32'(driving_cons), 32'd0);
    chk("s6_rst_cnt", 32'(fifo_count),   32'd0);
    chk("s6_rst_dv",  32'(dev_valid),    32'd0);
    tick();
    tick();
    arst_n_in = 1'b1;
    tick();
    tick();
    tick();
    #1;
    chk("s6_idle_dv",  32'(dev_valid),    32'd0);
    chk("s6_idle_drv", 32'(driving_cons), 32'd0);
    chk("s6_idle_cnt", 32'(fifo_count),   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
